ext_nonce_receive: RTL and testbench

- Receives 32-bit golden nonces from one external miner board over an async serial link (8N1, RxD idles high).
- Assembles 4 bytes into a word and presents it as nonce plus a one-cycle new_nonce pulse.
- One instance per external hub port; it sits directly upstream of hub_core and drives one 32-bit lane of slave_nonces and one bit of new_nonces.
- Byte order matches the miner-side serial_transmit: first byte on the wire is nonce[7:0].

---
 rtl/ext_nonce_receive_pkg.sv | 13 +
 rtl/ext_nonce_receive_if.sv | 9 +
 rtl/ext_nonce_receive_rx.sv | 63 ++++++
 rtl/ext_nonce_receive.sv | 61 ++++++
 tb/tb_ext_nonce_receive.sv | 116 +++++++++++
 5 files changed

// File: rtl/ext_nonce_receive_pkg.sv
// nonce_link_pkg: shared serial nonce link constants, FSM state codes and baud divisor
package nonce_link_pkg;
  localparam int NONCE_BYTES = 4;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_START = 3'd1;
  localparam state_t S_DATA = 3'd2;
  localparam state_t S_STOP = 3'd3;
  localparam state_t S_WAIT_HIGH = 3'd4;
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/ext_nonce_receive_if.sv
// ext_nonce_receive_if: serial line in (RxD), nonce/new_nonce/framing_error out; slave = receiver side
interface ext_nonce_receive_if;
  logic RxD;
  logic [31:0] nonce;
  logic new_nonce;
  logic framing_error;
  modport master(output RxD, input nonce, new_nonce, framing_error);
  modport slave(input RxD, output nonce, new_nonce, framing_error);
endinterface

// File: rtl/ext_nonce_receive_rx.sv
// uart_rx_byte: 8N1 byte receiver; ports clk, reset_n, rxd in; byte_data, byte_valid/framing_error pulses, idle flag out
module uart_rx_byte
  import nonce_link_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       framing_error,
  output logic       idle
);
  localparam int TW = $clog2(DIV);
  logic [1:0] sync;
  logic rx_prev;
  state_t state;
  logic [TW-1:0] tmr;
  logic [2:0] bit_idx;
  logic [7:0] sh;
  logic rx_s, expired;
  assign rx_s = sync[1];
  assign expired = tmr == '0;
  assign byte_data = sh;
  assign byte_valid = state == S_STOP && expired && rx_s;
  assign framing_error = state == S_STOP && expired && !rx_s;
  assign idle = state == S_IDLE;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= 2'b11;
      rx_prev <= 1'b1;
      state <= S_IDLE;
      tmr <= '0;
      bit_idx <= '0;
      sh <= '0;
    end else begin
      sync <= {sync[0], rxd};
      rx_prev <= rx_s;
      if (!expired) tmr <= tmr - 1'b1;
      case (state)
        S_IDLE: if (rx_prev && !rx_s) begin
          state <= S_START;
          tmr <= TW'(DIV / 2 - 1);
        end
        S_START: if (expired) begin
          state <= rx_s ? S_IDLE : S_DATA;
          tmr <= TW'(DIV - 1);
          bit_idx <= '0;
        end
        S_DATA: if (expired) begin
          sh <= {rx_s, sh[7:1]};
          tmr <= TW'(DIV - 1);
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) state <= S_STOP;
        end
        S_STOP: if (expired) state <= rx_s ? S_IDLE : S_WAIT_HIGH;
        S_WAIT_HIGH: if (rx_s) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/ext_nonce_receive.sv
// ext_nonce_receive: assembles 4 serial bytes (LSB byte first) into a nonce; ports clk, reset_n, link (slave)
module ext_nonce_receive
  import nonce_link_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int TIMEOUT_BITS = 40
) (
  input logic clk,
  input logic reset_n,
  ext_nonce_receive_if.slave link
);
  localparam int DIV = baud_div(CLK_HZ, BAUD_RATE);
  localparam int TO_CYC = TIMEOUT_BITS * DIV;
  localparam int GW = $clog2(TO_CYC + 1);
  logic [7:0] byte_data;
  logic byte_valid, fe, idle, timeout;
  logic [1:0] byte_cnt;
  logic [31:0] word, nonce_q;
  logic [GW-1:0] gap;
  logic new_q, fe_q;
  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clk(clk),
    .reset_n(reset_n),
    .rxd(link.RxD),
    .byte_data(byte_data),
    .byte_valid(byte_valid),
    .framing_error(fe),
    .idle(idle)
  );
  assign timeout = idle && byte_cnt != 2'd0 && gap == GW'(TO_CYC - 1);
  assign link.nonce = nonce_q;
  assign link.new_nonce = new_q;
  assign link.framing_error = fe_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt <= '0;
      word <= '0;
      gap <= '0;
      nonce_q <= '0;
      new_q <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      new_q <= 1'b0;
      fe_q <= fe;
      gap <= (idle && byte_cnt != 2'd0 && !timeout) ? gap + 1'b1 : '0;
      // timeout wins over a same-cycle start edge: the next byte lands in slot 0
      if (timeout || fe) begin
        byte_cnt <= '0;
        word <= '0;
      end else if (byte_valid) begin
        byte_cnt <= byte_cnt + 1'b1;
        word[8*byte_cnt +: 8] <= byte_data;
        if (byte_cnt == 2'(NONCE_BYTES - 1)) begin
          nonce_q <= {byte_data, word[23:0]};
          new_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ext_nonce_receive.sv
// tb_ext_nonce_receive: directed serial frames against hand-computed nonces
module tb_ext_nonce_receive;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0, errors = 0, news = 0, fes = 0, both = 0, n0 = 0, f0 = 0;
  ext_nonce_receive_if link();
  ext_nonce_receive #(.CLK_HZ(1600), .BAUD_RATE(100), .TIMEOUT_BITS(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .link(link.slave)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (reset_n) begin
    news += int'(link.new_nonce);
    fes += int'(link.framing_error);
    both += int'(link.new_nonce && link.framing_error);
  end
  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task bits(input logic v, input int n);
    link.RxD = v;
    repeat (n * 16) @(negedge clk);
  endtask
  task send_byte(input logic [7:0] b, input logic stop_ok);
    bits(1'b0, 1);
    for (int i = 0; i < 8; i++) bits(b[i], 1);
    if (stop_ok) bits(1'b1, 1);
    else begin
      bits(1'b0, 2);
      bits(1'b1, 1);
    end
  endtask
  task send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask
  task mark;
    n0 = news;
    f0 = fes;
  endtask
  initial begin
    link.RxD = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_nonce", link.nonce, 32'h0);
    check("rst_new", 32'(link.new_nonce), 32'h0);
    check("rst_fe", 32'(link.framing_error), 32'h0);
    reset_n = 1'b1;
    bits(1'b1, 2);
    mark();
    send_word(32'hDEADBEEF);
    bits(1'b1, 1);
    check("w1_nonce", link.nonce, 32'hDEADBEEF);
    check("w1_pulses", 32'(news - n0), 32'd1);
    check("w1_fe", 32'(fes - f0), 32'd0);
    mark();
    send_word(32'h00000001);
    check("b2b_nonce1", link.nonce, 32'h00000001);
    check("b2b_pulses1", 32'(news - n0), 32'd1);
    send_word(32'hFFFFFFFF);
    bits(1'b1, 1);
    check("b2b_nonce2", link.nonce, 32'hFFFFFFFF);
    check("b2b_pulses2", 32'(news - n0), 32'd2);
    mark();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    link.RxD = 1'b1;
    repeat (80) @(negedge clk);
    send_word(32'h11223344);
    bits(1'b1, 1);
    check("to_nonce", link.nonce, 32'h11223344);
    check("to_pulses", 32'(news - n0), 32'd1);
    mark();
    send_byte(8'h55, 1'b0);
    check("fe_pulses", 32'(fes - f0), 32'd1);
    check("fe_no_new", 32'(news - n0), 32'd0);
    send_word(32'h0A0B0C0D);
    bits(1'b1, 1);
    check("fe_nonce", link.nonce, 32'h0A0B0C0D);
    check("fe_new", 32'(news - n0), 32'd1);
    mark();
    link.RxD = 1'b0;
    repeat (5) @(negedge clk);
    bits(1'b1, 3);
    check("gl_new", 32'(news - n0), 32'd0);
    check("gl_fe", 32'(fes - f0), 32'd0);
    send_word(32'h12345678);
    bits(1'b1, 1);
    check("gl_nonce", link.nonce, 32'h12345678);
    check("gl_pulses", 32'(news - n0), 32'd1);
    mark();
    send_byte(8'hBE, 1'b1);
    bits(1'b0, 1);
    bits(1'b1, 2);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mr_nonce", link.nonce, 32'h0);
    check("mr_new", 32'(link.new_nonce), 32'h0);
    link.RxD = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bits(1'b1, 3);
    check("mr_no_pulse", 32'(news - n0), 32'd0);
    send_word(32'hCAFEBABE);
    bits(1'b1, 1);
    check("mr_nonce2", link.nonce, 32'hCAFEBABE);
    check("mr_pulses", 32'(news - n0), 32'd1);
    check("mr_fe", 32'(fes - f0), 32'd0);
    check("never_both", 32'(both), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
